elbeth_load_store_unit: RTL and testbench
=========================================

Name: elbeth_load_store_unit

Overview:
Data-side load/store unit between the EX/MEM pipeline stage and port B of the dual-port RAM (port A serves instruction fetch). It converts byte, half and word load/store requests into word-addressed RAM accesses with per-byte write strobes. It waits for the RAM's registered ready, then aligns and sign- or zero-extends load data. It stalls the pipeline while an access is in flight and flags misaligned and out-of-range accesses without touching memory.

Parameters:
AW, 8, RAM word-address width; addressable bytes = 4*2**AW.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ex_mem_req  in  1  access request valid; held until lsu_stall=0
ex_mem_we  in  1  1=store, 0=load
ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
ex_mem_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
ex_mem_addr  in  32  byte address
ex_mem_wdata  in  32  store data, right-justified
lsu_stall  out  1  pipeline hold
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  aligned/extended load result
lsu_exc_misaligned  out  1  misaligned or reserved-size access, valid with lsu_done
lsu_exc_fault  out  1  out-of-range access, valid with lsu_done
lsu_exc_addr  out  32  faulting byte address
dmem_enable  out  1  to RAM bmem_enable
dmem_addr  out  AW  to RAM bmem_addr = ex_mem_addr[AW+1:2]
dmem_data_in  out  32  to RAM bmem_data_in
dmem_wr  out  4  to RAM bmem_wr, byte strobes
dmem_data_out  in  32  from RAM bmem_data_out
dmem_ready  in  1  from RAM bmem_ready

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All registered outputs are 0: dmem_enable, dmem_wr, dmem_addr, dmem_data_in, lsu_done, lsu_rdata, both exc flags, lsu_exc_addr.
- The RAM samples enable/addr/wr on edge N. It asserts ready and valid data for cycle N+1. A write takes effect at edge N.
- States:
  - IDLE: on ex_mem_req=1, evaluate exceptions.
    - On exception: go to DONE with the flag set; dmem_enable is never asserted.
    - Otherwise: latch the request, drive the dmem_* registers, and go to ACCESS.
  - ACCESS: dmem_enable=1 for exactly this cycle. Go to WAIT; dmem_enable and dmem_wr return to 0.
  - WAIT: when dmem_ready=1, capture dmem_data_out (loads) and go to DONE. dmem_ready is ignored in every other state.
  - DONE: lsu_done=1 for one cycle, then IDLE.
- lsu_stall = ex_mem_req & (state != DONE), combinational. A normal access stalls 3 cycles (IDLE, ACCESS, WAIT); an exception stalls 1 cycle. A request is never accepted in DONE.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11.
- Fault: addr[31:AW+2] != 0.
- If both misaligned and fault apply, both flags assert. lsu_exc_addr = ex_mem_addr on any exception.
- Store steering:
  - byte: dmem_data_in = {4{wdata[7:0]}}, dmem_wr = 0001 << addr[1:0].
  - half: dmem_data_in = {2{wdata[15:0]}}, dmem_wr = addr[1] ? 1100 : 0011.
  - word: dmem_data_in = wdata, dmem_wr = 1111.
- Loads: dmem_wr = 0000. Result = dmem_data_out >> (8*addr[1:0]), truncated to the size, then extended per ex_mem_unsigned.
- lsu_rdata updates only on load completion and holds otherwise. Stores leave it unchanged.
- Exception flags are 0 except in DONE.
- Reset mid-access abandons the request. A RAM write already sampled at an edge is not undone.

Decomposition:
- elbeth_definitions.v gains:
  - size codes LSU_SIZE_B, LSU_SIZE_H, LSU_SIZE_W
  - state encodings LSU_IDLE, LSU_ACCESS, LSU_WAIT, LSU_DONE
- One combinational sub-module, elbeth_lsu_align: lane steering and strobe generation for stores, plus shift/extend for loads. The FSM and registers stay in the top module.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x43 -> lsu_rdata=0xFFFFFF88 on the lsu_done cycle; LBU addr 0x43 -> 0x00000088; each stalls exactly 3 cycles with one dmem_enable pulse and dmem_addr=0x10.
- Same word: LH 0x42 -> 0xFFFF8899; LHU 0x40 -> 0x0000AABB; LW 0x40 -> 0x8899AABB.
- SB addr 0x41, wdata 0x123456CC -> dmem_data_in=0xCCCCCCCC, dmem_wr=0010. Then SH 0x42, wdata 0x7777 -> dmem_wr=1100. Then LW 0x40 -> 0x7777CCBB.
- LW addr 0x42 -> no dmem_enable, lsu_stall high 1 cycle, lsu_exc_misaligned=1, lsu_exc_addr=0x42. SH 0x41 behaves the same.
- AW=8, LW addr 0x400 -> lsu_exc_fault=1, no memory access. LH addr 0x401 -> both flags set.
- rst=0 asserted during WAIT -> all outputs 0 immediately. A stale dmem_ready is ignored. A subsequent LW 0x40 completes normally in 3 cycles.
- Back-to-back: req held high across two instructions (LW then SW) -> second access starts in the cycle after DONE, with no lost or duplicated dmem_enable.

Source files
------------

// File: rtl/elbeth_load_store_unit_pkg.sv
// Shared encodings for the data-side load/store unit: access sizes, FSM states
// and the alignment rule applied to incoming requests.
package elbeth_load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam logic [1:0] LSU_IDLE   = 2'b00;
  localparam logic [1:0] LSU_ACCESS = 2'b01;
  localparam logic [1:0] LSU_WAIT   = 2'b10;
  localparam logic [1:0] LSU_DONE   = 2'b11;

  // The reserved size code is reported as misaligned so it never reaches memory.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      LSU_SIZE_B: mis = 1'b0;
      LSU_SIZE_H: mis = lo[0];
      LSU_SIZE_W: mis = (lo != 2'b00);
      default:    mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/elbeth_lsu_align.sv
// Lane steering and byte strobes for stores; shift, truncate and extend for loads.
module elbeth_lsu_align
  import elbeth_load_store_unit_pkg::*;
(
  input  logic        st_we_i,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_wr_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    st_data_o = st_wdata_i;
    st_wr_o   = 4'b0000;
    case (st_size_i)
      LSU_SIZE_B: begin
        st_data_o = {4{st_wdata_i[7:0]}};
        st_wr_o   = 4'b0001 << st_lo_i;
      end
      LSU_SIZE_H: begin
        st_data_o = {2{st_wdata_i[15:0]}};
        st_wr_o   = st_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      LSU_SIZE_W: st_wr_o = 4'b1111;
      default:    st_wr_o = 4'b0000;
    endcase
    if (!st_we_i) st_wr_o = 4'b0000;
  end

  assign shifted = ld_raw_i >> {ld_lo_i, 3'b000};

  always_comb begin
    case (ld_size_i)
      LSU_SIZE_B: ld_data_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_H: ld_data_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default:    ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/elbeth_load_store_unit.sv
// Data-side load/store unit: turns byte/half/word requests into word-addressed
// RAM port-B accesses, stalls the pipeline meanwhile, and flags bad addresses.
module elbeth_load_store_unit
  import elbeth_load_store_unit_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_mem_req,
  input  logic          ex_mem_we,
  input  logic [1:0]    ex_mem_size,
  input  logic          ex_mem_unsigned,
  input  logic [31:0]   ex_mem_addr,
  input  logic [31:0]   ex_mem_wdata,
  output logic          lsu_stall,
  output logic          lsu_done,
  output logic [31:0]   lsu_rdata,
  output logic          lsu_exc_misaligned,
  output logic          lsu_exc_fault,
  output logic [31:0]   lsu_exc_addr,
  output logic          dmem_enable,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_data_in,
  output logic [3:0]    dmem_wr,
  input  logic [31:0]   dmem_data_out,
  input  logic          dmem_ready
);

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d, uns_q, uns_d;
  logic [1:0]    size_q, size_d, lo_q, lo_d;
  logic          en_q, en_d, done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   din_q, din_d, rdata_q, rdata_d, xaddr_q, xaddr_d;
  logic [3:0]    wr_q, wr_d;
  logic          mis_q, mis_d, fault_q, fault_d;

  logic          req_mis, req_fault;
  logic [31:0]   st_data, ld_data;
  logic [3:0]    st_wr;

  assign req_mis   = lsu_misaligned(ex_mem_size, ex_mem_addr[1:0]);
  assign req_fault = (ex_mem_addr >> (AW + 2)) != 32'd0;

  elbeth_lsu_align u_align (
    .st_we_i       (ex_mem_we),
    .st_size_i     (ex_mem_size),
    .st_lo_i       (ex_mem_addr[1:0]),
    .st_wdata_i    (ex_mem_wdata),
    .st_data_o     (st_data),
    .st_wr_o       (st_wr),
    .ld_size_i     (size_q),
    .ld_lo_i       (lo_q),
    .ld_unsigned_i (uns_q),
    .ld_raw_i      (dmem_data_out),
    .ld_data_o     (ld_data)
  );

  // Enable, strobes, done and exception flags are single-cycle by default.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    xaddr_d = xaddr_q;
    en_d    = 1'b0;
    wr_d    = 4'b0000;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (ex_mem_req) begin
          if (req_mis || req_fault) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            mis_d   = req_mis;
            fault_d = req_fault;
            xaddr_d = ex_mem_addr;
          end else begin
            state_d = LSU_ACCESS;
            we_d    = ex_mem_we;
            uns_d   = ex_mem_unsigned;
            size_d  = ex_mem_size;
            lo_d    = ex_mem_addr[1:0];
            en_d    = 1'b1;
            wr_d    = st_wr;
            addr_d  = ex_mem_addr[AW+1:2];
            din_d   = st_data;
          end
        end
      end
      LSU_ACCESS: state_d = LSU_WAIT;
      LSU_WAIT: begin
        if (dmem_ready) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = ld_data;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      en_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      wr_q    <= 4'b0000;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      xaddr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      xaddr_q <= xaddr_d;
    end
  end

  assign lsu_stall          = ex_mem_req & (state_q != LSU_DONE);
  assign lsu_done           = done_q;
  assign lsu_rdata          = rdata_q;
  assign lsu_exc_misaligned = mis_q;
  assign lsu_exc_fault      = fault_q;
  assign lsu_exc_addr       = xaddr_q;
  assign dmem_enable        = en_q;
  assign dmem_addr          = addr_q;
  assign dmem_data_in       = din_q;
  assign dmem_wr            = wr_q;

endmodule

// File: tb/tb_elbeth_load_store_unit.sv
// Bench for elbeth_load_store_unit: byte-array memory model plus a port-B RAM
// with one-cycle registered ready; directed plan followed by random traffic.
module tb_elbeth_load_store_unit;

  localparam int AW = 8;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_mem_req = 1'b0, ex_mem_we = 1'b0, ex_mem_unsigned = 1'b0;
  logic [1:0]    ex_mem_size = 2'b00;
  logic [31:0]   ex_mem_addr = 32'd0, ex_mem_wdata = 32'd0;
  logic          lsu_stall, lsu_done, lsu_exc_misaligned, lsu_exc_fault;
  logic [31:0]   lsu_rdata, lsu_exc_addr;
  logic          dmem_enable;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_data_in, dmem_data_out;
  logic [3:0]    dmem_wr;
  logic          dmem_ready;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:NBYTES-1];
  logic [31:0] ram_q = 32'd0;
  logic        ram_rdy = 1'b0, stale_rdy = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  elbeth_load_store_unit #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_req(ex_mem_req), .ex_mem_we(ex_mem_we), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_exc_misaligned(lsu_exc_misaligned), .lsu_exc_fault(lsu_exc_fault),
    .lsu_exc_addr(lsu_exc_addr),
    .dmem_enable(dmem_enable), .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in),
    .dmem_wr(dmem_wr), .dmem_data_out(dmem_data_out), .dmem_ready(dmem_ready)
  );

  // RAM port B: write and read sampled at the edge, ready/data one cycle later.
  always @(posedge clk) begin
    ram_rdy <= dmem_enable;
    if (dmem_enable) begin
      ram_q <= ram[dmem_addr];
      for (int k = 0; k < 4; k++)
        if (dmem_wr[k]) ram[dmem_addr][8*k +: 8] <= dmem_data_in[8*k +: 8];
    end
  end
  assign dmem_data_out = ram_q;
  assign dmem_ready    = ram_rdy | stale_rdy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void put_word(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit uns);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input bit keep);
    int stalls, ens, bad, n;
    bit got, mis, flt;
    logic [31:0] c_addr, c_wr, c_din, r_xa, ew, ed;
    logic r_mis, r_flt;
    stalls = 0; ens = 0; bad = 0; got = 0;
    c_addr = 0; c_wr = 0; c_din = 0; r_xa = 0; r_mis = 0; r_flt = 0;
    ex_mem_req = 1'b1; ex_mem_we = we; ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_mem_addr = a; ex_mem_wdata = wd;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    flt = (a >> (AW + 2)) != 32'd0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (lsu_stall) stalls++;
      if (dmem_enable) begin
        ens++; c_addr = 32'(dmem_addr); c_wr = 32'(dmem_wr); c_din = dmem_data_in;
      end
      if (lsu_done) begin
        got = 1; r_mis = lsu_exc_misaligned; r_flt = lsu_exc_fault; r_xa = lsu_exc_addr;
      end else if (lsu_exc_misaligned || lsu_exc_fault) bad++;
    end
    @(posedge clk); #1;
    if (!keep) ex_mem_req = 1'b0;
    check_val("done_seen", 32'(got), 32'd1);
    check_val("flag_outside_done", bad, 0);
    check_val("exc_misaligned", 32'(r_mis), 32'(mis));
    check_val("exc_fault", 32'(r_flt), 32'(flt));
    if (mis || flt) begin
      check_val("exc_stall_cycles", stalls, 1);
      check_val("exc_enables", ens, 0);
      check_val("exc_addr", r_xa, a);
    end else begin
      check_val("stall_cycles", stalls, 3);
      check_val("enables", ens, 1);
      check_val("dmem_addr", c_addr, a >> 2);
      ew = 32'd0; ed = c_din;
      if (we) begin
        case (sz)
          2'd0: begin ew = 32'd1 << a[1:0]; ed = 32'(wd[7:0]) * 32'h01010101; end
          2'd1: begin ew = a[1] ? 32'd12 : 32'd3; ed = 32'(wd[15:0]) * 32'h00010001; end
          default: begin ew = 32'd15; ed = wd; end
        endcase
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
        check_val("store_data", c_din, ed);
      end else begin
        exp_rdata = ref_load(a, n, uns);
      end
      check_val("dmem_wr", c_wr, ew);
    end
    check_val("rdata", lsu_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    for (int w = 0; w < (1 << AW); w++) put_word(w, $urandom);
    put_word(32'h10, 32'h8899AABB);

    repeat (2) @(negedge clk);
    check_val("rst_enable", 32'(dmem_enable), 0);
    check_val("rst_done", 32'(lsu_done), 0);
    check_val("rst_rdata", lsu_rdata, 0);
    check_val("rst_flags", 32'({lsu_exc_misaligned, lsu_exc_fault}), 0);
    check_val("rst_outs", dmem_data_in | lsu_exc_addr | 32'(dmem_addr) | 32'(dmem_wr), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    run(0, 2'd0, 0, 32'h43, 0, 0); check_val("lb_43", lsu_rdata, 32'hFFFFFF88);
    run(0, 2'd0, 1, 32'h43, 0, 0); check_val("lbu_43", lsu_rdata, 32'h00000088);
    run(0, 2'd1, 0, 32'h42, 0, 0); check_val("lh_42", lsu_rdata, 32'hFFFF8899);
    run(0, 2'd1, 1, 32'h40, 0, 0); check_val("lhu_40", lsu_rdata, 32'h0000AABB);
    run(0, 2'd2, 0, 32'h40, 0, 0); check_val("lw_40", lsu_rdata, 32'h8899AABB);
    run(1, 2'd0, 0, 32'h41, 32'h123456CC, 0);
    run(1, 2'd1, 0, 32'h42, 32'h00007777, 0);
    run(0, 2'd2, 0, 32'h40, 0, 0); check_val("lw_after_st", lsu_rdata, 32'h7777CCBB);
    run(0, 2'd2, 0, 32'h42, 0, 0);
    run(1, 2'd1, 0, 32'h41, 32'h5555, 0);
    run(0, 2'd2, 0, 32'h400, 0, 0);
    run(0, 2'd1, 0, 32'h401, 0, 0);

    // Reset while the load sits in WAIT.
    ex_mem_req = 1'b1; ex_mem_we = 1'b0; ex_mem_size = 2'd2; ex_mem_addr = 32'h40;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check_val("mid_rst_enable_wr", 32'({dmem_enable, dmem_wr}), 0);
    check_val("mid_rst_done_flags", 32'({lsu_done, lsu_exc_misaligned, lsu_exc_fault}), 0);
    check_val("mid_rst_rdata", lsu_rdata, 0);
    check_val("mid_rst_outs", dmem_data_in | lsu_exc_addr | 32'(dmem_addr), 0);
    ex_mem_req = 1'b0; exp_rdata = 32'd0;
    @(negedge clk); rst = 1'b1; stale_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("stale_ready_done", 32'(lsu_done), 0);
    end
    stale_rdy = 1'b0;
    @(posedge clk); #1;
    run(0, 2'd2, 0, 32'h40, 0, 0);

    // Back-to-back with request held high.
    run(0, 2'd2, 0, 32'h40, 0, 1);
    run(1, 2'd2, 0, 32'h44, 32'hDEADBEEF, 0);
    run(0, 2'd2, 0, 32'h44, 0, 0); check_val("lw_b2b", lsu_rdata, 32'hDEADBEEF);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          1'($urandom_range(0, 1)));
      if (!ex_mem_req) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ex_mem_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
